rvc_mmio_timer_sc: RTL

// Memory-mapped timer on the core's D_MEM bus, in parallel with rvc_mem_wrap_sc.

---
 rtl/rvc_mmio_timer_sc.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rvc_mmio_timer_sc.sv
// Prescaled 32-bit MMIO timer (CTRL/STATUS/COUNT/COMPARE/PRESCALE) decoded beside the data memory.
// Reads are combinational (0 cycles), writes land on the next Clock edge; the bus is never stalled.
module rvc_mmio_timer_sc #(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic [31:0] AluOut,
  input  logic [31:0] RegRdData2,
  input  logic [3:0]  CtrlDMemByteEn,
  input  logic        CtrlDMemWrEn,
  input  logic        SelDMemWb,
  output logic        Hit,
  output logic [31:0] RdData,
  output logic        TimerIrq
);

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_COMPARE  = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  localparam logic [PRESCALE_W-1:0] PCNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic                  ctrlEn;
  logic                  ctrlAutoReload;
  logic                  ctrlIrqEn;
  logic                  matchFlag;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pcnt;

  logic                  ctrlEnNext;
  logic                  ctrlAutoReloadNext;
  logic                  ctrlIrqEnNext;
  logic                  matchFlagNext;
  logic [31:0]           countNext;
  logic [31:0]           compareNext;
  logic [PRESCALE_W-1:0] prescaleNext;
  logic [PRESCALE_W-1:0] pcntNext;

  logic [2:0]  regSel;
  logic        wrEn;
  logic        rdEn;
  logic        tick;
  logic        cmpHit;
  logic [31:0] laneMask;

  assign Hit      = (AluOut[31:5] == BASE_ADDR[31:5]);
  assign regSel   = AluOut[4:2];
  assign wrEn     = Hit & CtrlDMemWrEn;
  assign rdEn     = Hit & SelDMemWb;
  assign laneMask = {{8{CtrlDMemByteEn[3]}}, {8{CtrlDMemByteEn[2]}},
                     {8{CtrlDMemByteEn[1]}}, {8{CtrlDMemByteEn[0]}}};

  assign tick     = ctrlEn & (pcnt == prescale);
  assign cmpHit   = tick & (count == compare);
  assign TimerIrq = matchFlag & ctrlIrqEn;

  always_comb begin
    ctrlEnNext         = ctrlEn;
    ctrlAutoReloadNext = ctrlAutoReload;
    ctrlIrqEnNext      = ctrlIrqEn;
    matchFlagNext      = matchFlag;
    countNext          = count;
    compareNext        = compare;
    prescaleNext       = prescale;
    pcntNext           = pcnt;

    // A stale PCNT above a freshly lowered PRESCALE simply runs up and wraps.
    if (!ctrlEn || tick) begin
      pcntNext = '0;
    end else begin
      pcntNext = pcnt + PCNT_ONE;
    end

    if (tick) begin
      if (cmpHit && ctrlAutoReload) begin
        countNext = 32'd0;
      end else begin
        countNext = count + 32'd1;
      end
    end

    // Software lanes override the tick result lane by lane.
    if (wrEn) begin
      case (regSel)
        REG_CTRL: begin
          if (CtrlDMemByteEn[0]) begin
            ctrlEnNext         = RegRdData2[0];
            ctrlAutoReloadNext = RegRdData2[1];
            ctrlIrqEnNext      = RegRdData2[2];
          end
        end
        REG_STATUS: begin
          if (CtrlDMemByteEn[0] && RegRdData2[0]) begin
            matchFlagNext = 1'b0;
          end
        end
        REG_COUNT: begin
          countNext = (countNext & ~laneMask) | (RegRdData2 & laneMask);
        end
        REG_COMPARE: begin
          compareNext = (compare & ~laneMask) | (RegRdData2 & laneMask);
        end
        REG_PRESCALE: begin
          prescaleNext = (prescale & ~laneMask[PRESCALE_W-1:0])
                       | (RegRdData2[PRESCALE_W-1:0] & laneMask[PRESCALE_W-1:0]);
        end
        default: begin
        end
      endcase
    end

    // A new match beats a same-cycle write-1-to-clear.
    if (cmpHit) begin
      matchFlagNext = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      ctrlEn         <= 1'b0;
      ctrlAutoReload <= 1'b0;
      ctrlIrqEn      <= 1'b0;
      matchFlag      <= 1'b0;
      count          <= 32'd0;
      compare        <= 32'd0;
      prescale       <= '0;
      pcnt           <= '0;
    end else begin
      ctrlEn         <= ctrlEnNext;
      ctrlAutoReload <= ctrlAutoReloadNext;
      ctrlIrqEn      <= ctrlIrqEnNext;
      matchFlag      <= matchFlagNext;
      count          <= countNext;
      compare        <= compareNext;
      prescale       <= prescaleNext;
      pcnt           <= pcntNext;
    end
  end

  always_comb begin
    RdData = 32'd0;
    if (rdEn) begin
      case (regSel)
        REG_CTRL:     RdData = {29'd0, ctrlIrqEn, ctrlAutoReload, ctrlEn};
        REG_STATUS:   RdData = {31'd0, matchFlag};
        REG_COUNT:    RdData = count;
        REG_COMPARE:  RdData = compare;
        REG_PRESCALE: RdData[PRESCALE_W-1:0] = prescale;
        default:      RdData = 32'd0;
      endcase
    end
  end

endmodule
